// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the space-shooter game sequencer:
//               FSM state encoding, default obstacle count, score ceiling and
//               the saturating score adder.
//               Optional build macro SCORE_BCD_EN selects packed-BCD scoring
//               (00..99). Without it the score is plain binary (0..255).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    // Sequencer state encoding; the RGB selector decodes these values.
    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_PLAY    = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_WIN     = 3'd3,
        ST_OVER    = 3'd4
    } game_state_e;

    localparam int N_OBS_DEFAULT = 8;

`ifdef SCORE_BCD_EN
    localparam logic [7:0] SCORE_MAX = 8'h99;
`else
    localparam logic [7:0] SCORE_MAX = 8'd255;
`endif

    // Saturating add of a kill count onto the score.
    // In BCD mode the two digits are folded to a binary value, summed and
    // split back into digits. This gives the same result as a per-digit add
    // with carry, and it stays correct when the kill count exceeds 9.
    function automatic logic [7:0] score_add(input logic [7:0] s,
                                             input logic [7:0] n);
        logic [9:0] sum;
`ifdef SCORE_BCD_EN
        logic [9:0] val;
        val = (10'(s[7:4]) * 10'd10) + 10'(s[3:0]);
        sum = val + 10'(n);
        if (sum > 10'd99) begin
            return SCORE_MAX;
        end
        return {4'(sum / 10'd10), 4'(sum % 10'd10)};
`else
        sum = 10'(s) + 10'(n);
        if (sum > 10'd255) begin
            return SCORE_MAX;
        end
        return sum[7:0];
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_seq_kill_counter.sv
// ============================================================================
// Module      : kill_counter
// Description : Detects obstacle kills (alive 1->0 transitions) and keeps the
//               saturating kill score. Binary scoring by default; packed BCD
//               when SCORE_BCD_EN is defined.
// Ports       : clk, reset      - clock, async active-high reset
//               obs_alive[N]    - obstacle alive flags
//               count_en        - score kills this cycle (sequencer in PLAY)
//               clear           - zero the score (start of a new game)
//               mask            - suppress kills around an obstacle respawn
//               score[8]        - registered score
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kill_counter
    import game_pkg::*;
#(
    parameter int N_OBS = N_OBS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_OBS-1:0] obs_alive,
    input  logic             count_en,
    input  logic             clear,
    input  logic             mask,
    output logic [7:0]       score
);

    logic [N_OBS-1:0] prev_alive_q;
    logic [N_OBS-1:0] prev_alive_d;
    logic [7:0]       score_q;
    logic [7:0]       score_d;
    logic [N_OBS-1:0] kills;
    logic [7:0]       kill_cnt;

    always_comb begin
        prev_alive_d = obs_alive;
        kills        = prev_alive_q & ~obs_alive;

        kill_cnt = 8'd0;
        for (int i = 0; i < N_OBS; i++) begin
            kill_cnt = kill_cnt + 8'(kills[i]);
        end

        score_d = score_q;
        if (clear) begin
            score_d = 8'd0;
        end else if (count_en && !mask) begin
            score_d = score_add(score_q, kill_cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_alive_q <= '0;
            score_q      <= 8'd0;
        end else begin
            prev_alive_q <= prev_alive_d;
            score_q      <= score_d;
        end
    end

    assign score = score_q;

endmodule

`default_nettype wire

// File: rtl/game_seq.sv
// ============================================================================
// Module      : game_seq
// Description : Top-level game sequencer. Runs the attract / play / clear /
//               win / game-over flow, the wave counter and the per-wave
//               countdown. It requests obstacle respawns and gates ship and
//               bullet motion through play_en.
//               Optional macro SCORE_BCD_EN: the score is two packed BCD
//               digits, handled inside kill_counter.
// Ports       : clk, reset      - clock, async active-high reset
//               frame_tick      - one-cycle pulse per video frame
//               fire            - raw asynchronous fire button
//               obs_alive[N]    - obstacle alive flags
//               state[3]        - current state (game_state_e encoding)
//               play_en         - high only in PLAY
//               respawn         - one-cycle obstacle restore request
//               wave[4]         - current wave, 0-based
//               score[8]        - saturating kill count
//               time_left[11]   - frames remaining in the wave
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_seq
    import game_pkg::*;
#(
    parameter int TIME_LIMIT   = 1800,
    parameter int CLEAR_FRAMES = 120,
    parameter int NUM_WAVES    = 4,
    parameter int N_OBS        = N_OBS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             fire,
    input  logic [N_OBS-1:0] obs_alive,
    output logic [2:0]       state,
    output logic             play_en,
    output logic             respawn,
    output logic [3:0]       wave,
    output logic [7:0]       score,
    output logic [10:0]      time_left
);

    localparam int          CLR_W     = (CLEAR_FRAMES > 1) ? $clog2(CLEAR_FRAMES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLEAR_FRAMES - 1);
    localparam logic [3:0]  LAST_WAVE = 4'(NUM_WAVES - 1);
    localparam logic [10:0] TIME_INIT = 11'(TIME_LIMIT);

    // Fire button synchronizer and edge detector
    logic fire_meta_q, fire_sync_q, fire_prev_q;
    logic fire_rise;

    // Sequencer registers
    game_state_e      state_q, state_d;
    logic             play_en_q, play_en_d;
    logic             respawn_q, respawn_d;
    logic             respawn_dly_q;
    logic [3:0]       wave_q, wave_d;
    logic [10:0]      time_left_q, time_left_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic score_clear;
    logic count_en;
    logic mask;
    logic all_dead;

    assign fire_rise = fire_sync_q & ~fire_prev_q;

    // The obstacle bank restores its flags during the respawn cycle, so the
    // alive vector is not trustworthy until two cycles after the pulse.
    assign mask     = respawn_q | respawn_dly_q;
    assign count_en = (state_q == ST_PLAY);
    assign all_dead = (obs_alive == '0);

    always_comb begin
        state_d     = state_q;
        wave_d      = wave_q;
        time_left_d = time_left_q;
        clr_cnt_d   = clr_cnt_q;
        respawn_d   = 1'b0;
        score_clear = 1'b0;

        case (state_q)
            ST_ATTRACT: begin
                if (fire_rise) begin
                    state_d     = ST_PLAY;
                    respawn_d   = 1'b1;
                    score_clear = 1'b1;
                    wave_d      = 4'd0;
                    time_left_d = TIME_INIT;
                end
            end

            ST_PLAY: begin
                // Clearing the field outranks a timeout in the same cycle.
                if (all_dead && !mask) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (frame_tick) begin
                    if (time_left_q <= 11'd1) begin
                        state_d     = ST_OVER;
                        time_left_d = 11'd0;
                    end else begin
                        time_left_d = time_left_q - 11'd1;
                    end
                end
            end

            ST_CLEAR: begin
                if (frame_tick) begin
                    if (clr_cnt_q == CLR_LAST) begin
                        if (wave_q == LAST_WAVE) begin
                            state_d = ST_WIN;
                        end else begin
                            state_d     = ST_PLAY;
                            wave_d      = wave_q + 4'd1;
                            time_left_d = TIME_INIT;
                            respawn_d   = 1'b1;
                        end
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end

            ST_WIN, ST_OVER: begin
                if (fire_rise) begin
                    state_d = ST_ATTRACT;
                end
            end

            default: begin
                state_d = ST_ATTRACT;
            end
        endcase

        play_en_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_meta_q   <= 1'b0;
            fire_sync_q   <= 1'b0;
            fire_prev_q   <= 1'b0;
            state_q       <= ST_ATTRACT;
            play_en_q     <= 1'b0;
            respawn_q     <= 1'b0;
            respawn_dly_q <= 1'b0;
            wave_q        <= 4'd0;
            time_left_q   <= TIME_INIT;
            clr_cnt_q     <= '0;
        end else begin
            fire_meta_q   <= fire;
            fire_sync_q   <= fire_meta_q;
            fire_prev_q   <= fire_sync_q;
            state_q       <= state_d;
            play_en_q     <= play_en_d;
            respawn_q     <= respawn_d;
            respawn_dly_q <= respawn_q;
            wave_q        <= wave_d;
            time_left_q   <= time_left_d;
            clr_cnt_q     <= clr_cnt_d;
        end
    end

    kill_counter #(
        .N_OBS (N_OBS)
    ) u_kill_counter (
        .clk       (clk),
        .reset     (reset),
        .obs_alive (obs_alive),
        .count_en  (count_en),
        .clear     (score_clear),
        .mask      (mask),
        .score     (score)
    );

    assign state     = state_q;
    assign play_en   = play_en_q;
    assign respawn   = respawn_q;
    assign wave      = wave_q;
    assign time_left = time_left_q;

endmodule

`default_nettype wire

// File: doc/game_seq.md
Name: game_seq

Overview:
- Top-level game sequencer for the space shooter.
- Owns the play / wave-clear / win / game-over flow and the wave counter, score and countdown timer.
- Tells the obstacle bank when to respawn; the RGB selector reads its state; play_en gates ship and bullet movement.
- Sits beside the VGA sync unit and reads the 8 obstacle alive flags.

Parameters:
- TIME_LIMIT, 1800: frames per wave (30 s at 60 Hz); 11-bit max.
- CLEAR_FRAMES, 120: frames held in CLEAR before the next wave.
- NUM_WAVES, 4: waves to clear for WIN (1..15).
- N_OBS, 8: number of obstacle alive flags.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (end of vsync)
- fire  in  1  raw fire button, asynchronous, active-high
- obs_alive  in  N_OBS  1 = obstacle i alive
- state  out  3  current FSM state (encoding in package)
- play_en  out  1  high only in PLAY
- respawn  out  1  one-cycle pulse; obstacle bank restores all obstacles
- wave  out  4  current wave index, 0-based
- score  out  8  kill count, saturating
- time_left  out  11  frames remaining in the current wave

Behaviour:
- Reset (async assert, sync release) sets:
  - state=ATTRACT, play_en=0, respawn=0, wave=0, score=0, time_left=TIME_LIMIT.
  - Sync flops and prev_alive are cleared to 0.
- fire path: 2-flop synchronizer, then rising-edge detect (fire_rise).
  - Latency from a fire edge to the state change is 3 clk cycles.
- Kill detect: prev_alive registered every cycle; kills = prev_alive & ~obs_alive.
  - Kills are counted only in PLAY and only when mask=0.
  - mask is high in the respawn cycle and the cycle after it.
- score += popcount(kills); saturates at 255, never wraps.
- All outputs are registered. respawn is high for exactly one cycle, in the cycle the new state is entered.
- ATTRACT:
  - fire_rise -> PLAY, respawn=1, score=0, wave=0, time_left=TIME_LIMIT.
- PLAY:
  - Priority 1: obs_alive==0 with mask=0 -> CLEAR, and the clear counter resets to 0.
  - Priority 2: frame_tick with time_left==1 -> OVER, time_left=0.
  - Otherwise frame_tick decrements time_left.
  - A final kill in the same cycle as the timeout: the kill is scored and CLEAR wins.
- CLEAR:
  - Counts frame_ticks; on the CLEAR_FRAMES-th tick:
    - if wave==NUM_WAVES-1 -> WIN, wave unchanged;
    - else wave+1, time_left=TIME_LIMIT, respawn=1 -> PLAY.
  - fire is ignored.
- WIN / OVER:
  - Outputs hold (score and wave frozen); fire_rise -> ATTRACT.
  - No respawn pulse here; it is issued on ATTRACT->PLAY.
- frame_tick and fire_rise in the same cycle: each is handled by the current state's rules; they do not interact.
- Reset mid-wave: immediate return to ATTRACT with all counters reset; any respawn pulse is cancelled.
- Undefined state encodings recover to ATTRACT.

Optional Feature:
- Macro: SCORE_BCD_EN.
- Defined: score is two packed BCD digits (00..99).
  - Adding the popcount carries per digit; the result saturates at 8'h99.
- Undefined: score is plain binary, saturating at 255.
- Port width is 8 in both cases.

Decomposition:
- Shared package game_pkg:
  - state localparams ST_ATTRACT=0, ST_PLAY=1, ST_CLEAR=2, ST_WIN=3, ST_OVER=4;
  - N_OBS default;
  - SCORE_MAX binary=255 / BCD=8'h99.
- One sub-module: kill_counter.
  - Contains prev_alive, mask handling, popcount and the saturating (optionally BCD) score register.
  - Takes count_en, clear and mask inputs from the FSM.
- FSM, timer and wave counter stay in game_seq.

Test Plan:
- Reset, then pulse fire 1 cycle -> state=PLAY 3 cycles later; respawn high exactly 1 cycle; time_left=1800; score=0.
- In PLAY, drop obs_alive 8'hFF->8'hFC in one cycle -> score=2; then 8'hFC->8'h00 -> score=8, state=CLEAR next cycle.
- In CLEAR, 120 frame_ticks with NUM_WAVES=4, wave=0 -> wave=1, respawn pulse, state=PLAY, time_left=1800; alive drop within the 2-cycle mask is not scored.
- In PLAY, 1800 frame_ticks with obstacles alive -> state=OVER, time_left=0; further kills leave score unchanged; fire -> ATTRACT.
- Last obstacle killed in the same cycle as the final frame_tick -> state=CLEAR, not OVER; clear wave 3 -> WIN.
- Score saturation: force 260 kills -> score=255 without SCORE_BCD_EN, 8'h99 with it. Assert reset mid-CLEAR -> all outputs at reset values.
